// File: rtl/encoder_8_3_seq.sv
// encoder_8_3_seq
//   Sequential 8-to-3 encoder. Accepts a multi-hot request vector through a
//   valid/ready handshake and streams out one 3-bit index per output beat,
//   flagging the final index of each vector with Out_last.
//
// Parameters
//   RR_EN      0: fixed priority, highest set bit first
//              1: round-robin, search starts at (last granted index + 1) mod 8
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   E          enable; gates acceptance of new vectors only
//   req_valid  In holds a vector to encode
//   req_ready  block can accept a vector this cycle (E && IDLE)
//   In         multi-hot request vector
//   code_valid Out holds a valid index
//   code_ready consumer takes Out this cycle
//   Out        encoded bit index
//   Out_last   Out is the final index of the current vector
//   pend       requests not yet emitted, excluding the one on Out
module encoder_8_3_seq #(
  parameter int unsigned RR_EN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] In,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [2:0] Out,
  output logic       Out_last,
  output logic [7:0] pend
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_last_ptr;

  logic [7:0] w_src;
  logic [2:0] w_sel;
  logic [7:0] w_pend_nx;

  function automatic logic [2:0] f_select(input logic [7:0] v, input logic [2:0] lp);
    logic [2:0] idx;
    logic [2:0] sel;
    logic       found;
    sel   = '0;
    found = 1'b0;
    if (RR_EN == 0) begin
      // Ascending scan; the last hit wins, giving the highest set bit.
      for (int unsigned i = 0; i < 8; i++) begin
        if (v[i]) sel = 3'(i);
      end
    end else begin
      // Wrap-around scan starting one past the last grant.
      for (int unsigned k = 1; k <= 8; k++) begin
        idx = lp + 3'(k);
        if (!found && v[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

  // One selector serves both the accept path (In) and the drain path (pend).
  always_comb begin
    w_src     = (r_state == S_IDLE) ? In : pend;
    w_sel     = f_select(w_src, r_last_ptr);
    w_pend_nx = w_src & ~(8'd1 << w_sel);
  end

  assign req_ready = E && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last_ptr <= 3'd7;
      code_valid <= 1'b0;
      Out        <= '0;
      Out_last   <= 1'b0;
      pend       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready && (In != '0)) begin
            Out        <= w_sel;
            pend       <= w_pend_nx;
            Out_last   <= (w_pend_nx == '0);
            r_last_ptr <= w_sel;
            code_valid <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (code_valid && code_ready) begin
            if (pend != '0) begin
              Out        <= w_sel;
              pend       <= w_pend_nx;
              Out_last   <= (w_pend_nx == '0);
              r_last_ptr <= w_sel;
            end else begin
              code_valid <= 1'b0;
              Out_last   <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
